// File: rtl/vx_wb_arbiter.sv
// Writeback arbiter: merges result beats from NUM_INPUTS execute units into a
// single writeback stream. Round-robin grant with a per-packet lock, one
// registered output stage and a one-entry skid buffer. The skid buffer lets
// in_ready depend only on registered state, never on out_ready.
//
// Handshake: a beat moves on any port in a cycle where its valid and ready
// are both high. in_ready[i] may be high while in_valid[i] is low, which
// happens for the locked unit when it has no beat ready. out_data and out_eop
// hold steady while out_valid is high and out_ready is low.
module vx_wb_arbiter #(
    parameter int NUM_INPUTS    = 4,
    parameter int DATAW         = 128,
    parameter int PERF_CTR_BITS = 44
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         in_valid,
    input  logic [NUM_INPUTS*DATAW-1:0]   in_data,
    input  logic [NUM_INPUTS-1:0]         in_eop,
    output logic [NUM_INPUTS-1:0]         in_ready,
    output logic                          out_valid,
    output logic [DATAW-1:0]              out_data,
    output logic                          out_eop,
    input  logic                          out_ready,
    output logic [PERF_CTR_BITS-1:0]      perf_stalls
);

    localparam int IDXW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    // (base + off) mod NUM_INPUTS, for off in [0, NUM_INPUTS)
    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
        return sum[IDXW-1:0];
    endfunction

    logic [IDXW-1:0]  ptr;
    logic             lock;
    logic [IDXW-1:0]  lock_idx;
    logic             skid_valid;
    logic [DATAW-1:0] skid_data;
    logic             skid_eop;

    logic [DATAW-1:0] in_beats [NUM_INPUTS];
    logic             sel_any;
    logic [IDXW-1:0]  sel_idx;
    logic             accept;
    logic             out_free;
    logic [DATAW-1:0] acc_data;
    logic             acc_eop;

    // Unpack the flat input bus into one word per unit
    always_comb begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
            in_beats[i] = in_data[i*DATAW +: DATAW];
        end
    end

    // Pick the granted unit: the locked unit, else first valid at or after ptr.
    // Scanning from the far end down lets the nearest valid unit win.
    always_comb begin
        sel_any = 1'b0;
        sel_idx = ptr;
        if (lock) begin
            sel_any = 1'b1;
            sel_idx = lock_idx;
        end else begin
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (in_valid[wrap_idx(ptr, k)]) begin
                    sel_any = 1'b1;
                    sel_idx = wrap_idx(ptr, k);
                end
            end
        end
    end

    // Ready goes to the granted unit only while the skid buffer has room
    always_comb begin
        in_ready = '0;
        if (sel_any && !skid_valid && reset) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    assign accept   = |(in_valid & in_ready);
    assign acc_data = in_beats[sel_idx];
    assign acc_eop  = in_eop[sel_idx];
    assign out_free = !out_valid || out_ready;

    // Round-robin pointer and packet lock advance on each accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (accept) begin
            if (acc_eop) begin
                lock <= 1'b0;
                ptr  <= wrap_idx(sel_idx, 1);
            end else begin
                lock     <= 1'b1;
                lock_idx <= sel_idx;
            end
        end
    end

    // Output register and skid buffer; the skid beat always drains first
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_eop    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_eop   <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                out_eop    <= skid_eop;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= acc_data;
                out_eop   <= acc_eop;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= acc_data;
            skid_eop   <= acc_eop;
        end
    end

    // Count cycles in which some unit offers a beat that is not taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stalls <= '0;
        end else if (|(in_valid & ~in_ready)) begin
            perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
        end
    end

endmodule

// File: tb/tb_vx_wb_arbiter.sv
// Bench for vx_wb_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference.
module tb_vx_wb_arbiter;
  localparam int N     = 4;
  localparam int DATAW = 128;
  localparam int PCB   = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]       in_valid;
  logic [N*DATAW-1:0] in_data;
  logic [N-1:0]       in_eop;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [DATAW-1:0]   out_data;
  logic               out_eop;
  logic               out_ready;
  logic [PCB-1:0]     perf_stalls;

  vx_wb_arbiter #(.NUM_INPUTS(N), .DATAW(DATAW), .PERF_CTR_BITS(PCB)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_eop(in_eop),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_eop(out_eop),
    .out_ready(out_ready),
    .perf_stalls(perf_stalls)
  );

  // ---------------- reference model ----------------
  // Beats accepted but not yet consumed, oldest first: {eop, data}
  logic [DATAW:0] exp_q[$];
  int             m_ptr;
  bit             m_lock;
  int             m_lock_idx;
  logic [PCB-1:0] m_perf;
  logic [N-1:0]   m_acc;

  int errors = 0;
  int checks = 0;

  // ---------------- stimulus state ----------------
  int               pkt_left [N];
  logic [DATAW-1:0] cur_data [N];
  int               seq = 0;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Two beats outstanding means output and skid are both occupied
  function automatic logic [N-1:0] model_ready();
    if (!reset) return '0;
    if (exp_q.size() >= 2) return '0;
    if (m_lock) return N'(1) << m_lock_idx;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (in_valid[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 0;
    m_lock = 1'b0;
    m_lock_idx = 0;
    m_perf = '0;
    m_acc  = '0;
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    logic [N-1:0] r;
    r = model_ready();
    m_acc = in_valid & r;
    if (|(in_valid & ~r)) m_perf = m_perf + 1'b1;
    if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        exp_q.push_back({in_eop[i], in_data[i*DATAW +: DATAW]});
        if (in_eop[i]) begin
          m_lock = 1'b0;
          m_ptr  = (i + 1) % N;
        end else begin
          m_lock = 1'b1;
          m_lock_idx = i;
        end
      end
    end
  endtask

  // Compare all outputs against the model
  task automatic compare();
    chk("in_ready", in_ready, model_ready());
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      chk("out_data", out_data, exp_q[0][DATAW-1:0]);
      chk("out_eop", out_eop, exp_q[0][DATAW]);
    end
    chk("perf_stalls", perf_stalls, m_perf);
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [DATAW-1:0] new_beat(input int unit);
    logic [DATAW-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    d[DATAW-1 -: 8]  = 8'(unit);
    d[DATAW-9 -: 24] = 24'(seq);
    seq++;
    return d;
  endfunction

  task automatic pack_data();
    for (int i = 0; i < N; i++) in_data[i*DATAW +: DATAW] = cur_data[i];
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  task automatic drive_random(input int ready_pct);
    out_ready = ($urandom_range(0, 99) < ready_pct);
    for (int i = 0; i < N; i++) begin
      if (pkt_left[i] == 0) pkt_left[i] = $urandom_range(1, 3);
      in_valid[i] = ($urandom_range(0, 3) != 0);
      in_eop[i]   = (pkt_left[i] == 1);
    end
    pack_data();
  endtask

  task automatic gen_update();
    for (int i = 0; i < N; i++) begin
      if (m_acc[i]) begin
        pkt_left[i]--;
        cur_data[i] = new_beat(i);
      end
    end
  endtask

  task automatic run_random(input int cycles);
    int pct;
    pct = 100;
    for (int c = 0; c < cycles; c++) begin
      if (c % 150 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 30;
          1: pct = 70;
          default: pct = 100;
        endcase
      end
      drive_random(pct);
      settle();
      model_step();
      gen_update();
      @(negedge clk);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = '1;
    in_eop    = '1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      cur_data[i] = new_beat(i);
      pkt_left[i] = 0;
    end
    pack_data();
    model_reset();

    // Held in reset with every unit requesting
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 4'b0000);
    chk("rst_perf", perf_stalls, 0);

    // Release: all single-beat, rotation 0,1,2,3,0 with continuous output
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rot_in_ready", in_ready, 4'b0001 << (k % 4));
      chk("rot_out_valid", out_valid, k > 0);
      if (k > 0) chk("rot_out_data", out_data, cur_data[(k - 1) % 4]);
      chk("rot_perf", perf_stalls, k);
      advance();
    end

    // Unit 1 locks with a 2-beat packet, stalls 2 cycles, unit 0 waits
    in_valid = 4'b0011; in_eop = 4'b0000;
    settle();
    chk("lock_first", in_ready, 4'b0010);
    advance();
    in_valid = 4'b0001; in_eop = 4'b0001;
    settle();
    chk("lock_bubble1", in_ready, 4'b0010);
    advance();
    settle();
    chk("lock_bubble2", in_ready, 4'b0010);
    advance();
    in_valid = 4'b0011; in_eop = 4'b0011;
    settle();
    chk("lock_eop", in_ready, 4'b0010);
    advance();
    in_valid = 4'b0001;
    settle();
    chk("lock_release", in_ready, 4'b0001);
    advance();

    // Randomized traffic with varying back-pressure
    for (int i = 0; i < N; i++) cur_data[i] = new_beat(i);
    run_random(1500);

    // Back-pressure with mid-packet beats until output and skid are full
    in_valid  = 4'b1111;
    in_eop    = 4'b0000;
    out_ready = 1'b0;
    pack_data();
    for (int k = 0; k < 4; k++) begin
      settle();
      advance();
    end
    settle();
    chk("full_in_ready", in_ready, 4'b0000);
    chk("full_out_valid", out_valid, 1'b1);

    // Reset while full: outputs clear immediately
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 4'b0000);
    chk("midrst_perf", perf_stalls, 0);
    model_reset();
    for (int i = 0; i < N; i++) pkt_left[i] = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    in_valid  = 4'b1010;
    in_eop    = 4'b1111;
    settle();
    chk("post_rst_grant", in_ready, 4'b0010);
    advance();

    run_random(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
